fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder buffer for the radix-2 pipelined FFT. It sits after the last `fftstg` and consumes that stage's `en_out`/`cnt_out`/`yout_*` stream, in which the sample at frame position `cnt` is FFT bin `bitrev(cnt)`. It re-emits each 2^N-point frame in natural bin order, with a matching enable/count stream. It uses a ping-pong pair of 2^N-entry complex buffers, so continuous back-to-back frames pass without stalls.

## Interface
- `width`, 16, bit width of each real/imaginary sample (signed)
- `N`, 6, log2 of FFT length; frame = 2^N samples

- `clk`  in  1  single clock, all logic on rising edge
- `areset`  in  1  reset, synchronous, active-high
- `en_in`  in  1  input sample valid
- `cnt_in`  in  N  frame position of input sample (bit-reversed bin index)
- `xin_re`  in  width  input real part, signed
- `xin_im`  in  width  input imaginary part, signed
- `en_out`  out  1  output sample valid
- `cnt_out`  out  N  natural-order bin index of output sample
- `yout_re`  out  width  output real part, signed
- `yout_im`  out  width  output imaginary part, signed
- `err`  out  1  sticky protocol-error flag

## Operation
- Two banks, B0 and B1, each holding 2^N entries of {re, im}.
- `wbank` selects the bank being written. The reader uses the other bank.
- Write side:
  - On every cycle with `en_in`=1, store {`xin_re`,`xin_im`} at `wbank[bitrev(cnt_in)]`, where bitrev reverses all N bits.
  - `cnt_in` alone sets the address. Gaps (`en_in`=0) inside a frame are legal; data is held.
- Frame completion: a write with `cnt_in`=2^N-1 completes the frame. On that edge:
  - `wbank` toggles.
  - The just-filled bank is handed to the reader (`rbank` <= old `wbank`).
  - `start` pulses.
- Reader FSM with states IDLE and READ:
  - IDLE -> READ on `start`; `rcnt` <= 0.
  - In READ, each cycle: `yout` <= `rbank[rcnt]`, `cnt_out` <= `rcnt`, `en_out` <= 1, `rcnt` <= `rcnt`+1.
  - On the cycle that outputs `rcnt`=2^N-1: go to IDLE unless `start` fires on the same edge. If it does, stay in READ with `rcnt` <= 0 and the new `rbank`, giving seamless back-to-back frames.
  - In IDLE: `en_out` <= 0. `yout_*` and `cnt_out` hold their last values.
- Overrun: a `start` arriving while READ has `rcnt` != 2^N-1 means the reader is still busy.
  - Set `err`.
  - Restart the read at `rcnt`=0 on the new bank; the partially read frame is abandoned.
  - This cannot occur with a legal stream, since a writer frame takes at least 2^N cycles.
- Sequence check: `exp_cnt` tracks the next expected `cnt_in`. It resets to 0, advances on each `en_in`, and wraps 2^N-1 -> 0.
  - `en_in`=1 with `cnt_in` != `exp_cnt` sets `err`.
  - The sample is still written at `bitrev(cnt_in)`, and `exp_cnt` resyncs to `cnt_in`+1.
- `err` clears only on reset.
- No arithmetic is performed. Data passes bit-exact; widths are unchanged.

## Timing
- Reset values (`areset`=1 at an edge): `en_out`=0, `cnt_out`=0, `yout_re`=0, `yout_im`=0, `err`=0. Internal state also resets: `wbank`=B0, FSM=IDLE, `rcnt`=0, `exp_cnt`=0.
- Buffer contents are not cleared by reset. They are never read before being rewritten.
- Reset mid-frame discards both the partial write and any in-progress read. The first frame accepted after reset must start at `cnt_in`=0, otherwise `err` sets.
- Latency: if the last input sample (`cnt_in`=2^N-1) is captured at edge T, then bin 0 is on `yout_*` with `en_out`=1 after edge T+1. Bin k appears after edge T+1+k.
- `en_out` stays high for exactly 2^N consecutive cycles per frame, or longer when frames are back-to-back.
- Throughput is one sample per clock. There is no backpressure; the downstream consumer must accept every `en_out` cycle.
- A simultaneous write and read never touch the same bank, except in the overrun case, which is flagged.

## Test plan
- N=3, one frame, `xin_re`=`cnt_in` for `cnt_in` 0..7, `xin_im`=-`cnt_in` -> `yout_re` = 0,4,2,6,1,5,3,7 and `yout_im` = their negatives, with `cnt_out` 0..7. `en_out` high on 8 consecutive cycles starting one cycle after the last input. `err`=0.
- Three back-to-back N=3 frames with `xin_re`=16*frame+`cnt_in` -> 24 continuous `en_out` cycles with no gap, each frame bit-reverse permuted, and no mixing between banks.
- One N=3 frame with `en_in` dropped for 5 cycles after `cnt_in`=3 -> output identical to the gapless case, starting one cycle after the delayed last sample.
- `cnt_in` sequence 0,1,2,5,6,7 -> `err`=1 from the edge capturing 5 and stays 1. The frame still completes at 7 and is emitted; entries never written show prior contents.
- Reset asserted at `cnt_in`=4 of a frame, then a clean frame -> outputs 0 immediately, `en_out`=0 until one cycle after the new frame's last sample, and the new frame is output correctly with `err`=0.
- Default N=6, random signed data including -32768 and 32767 -> `yout` at `cnt_out`=k equals the input at `cnt_in`=`bitrev6(k)`, bit-exact.

Source files
------------

// File: rtl/fft_reorder.sv
// fft_reorder: output reorder buffer for the radix-2 pipelined FFT.
// Accepts the bit-reversed-order stream from the last FFT stage and
// re-emits every 2^N-point frame in natural bin order. A ping-pong pair of
// 2^N-entry complex banks lets back-to-back frames pass without stalls.
//
// Ports:
//   clk      in   single clock, rising edge
//   areset   in   synchronous active-high reset
//   en_in    in   input sample valid
//   cnt_in   in   frame position of the input sample (bit-reversed bin)
//   xin_re   in   input real part, signed
//   xin_im   in   input imaginary part, signed
//   en_out   out  output sample valid
//   cnt_out  out  natural-order bin index of the output sample
//   yout_re  out  output real part, signed
//   yout_im  out  output imaginary part, signed
//   err      out  sticky protocol error (sequence break or reader overrun)
//
// Reader FSM:
//   state | meaning
//   IDLE  | no frame being emitted, en_out low, outputs hold
//   READ  | emitting the bank in rbank_q, one bin per cycle
module fft_reorder #(
    parameter int width = 16,
    parameter int N     = 6
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    en_in,
    input  logic [N-1:0]            cnt_in,
    input  logic signed [width-1:0] xin_re,
    input  logic signed [width-1:0] xin_im,
    output logic                    en_out,
    output logic [N-1:0]            cnt_out,
    output logic signed [width-1:0] yout_re,
    output logic signed [width-1:0] yout_im,
    output logic                    err
);

    localparam int         DEPTH = 1 << N;
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    // Buffer contents are deliberately not reset: every entry is rewritten
    // before the reader can reach it.
    logic [2*width-1:0] bank0_mem [DEPTH];
    logic [2*width-1:0] bank1_mem [DEPTH];

    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic [N-1:0]       exp_cnt_q, exp_cnt_d;
    logic               err_q, err_d;
    state_t             state_q;
    logic [N-1:0]       rcnt_q;
    logic               en_out_q;
    logic [N-1:0]       cnt_out_q;
    logic [width-1:0]   yout_re_q, yout_im_q;

    logic               start;
    logic               seq_bad;
    logic               overrun;
    logic [N-1:0]       wr_addr;
    logic [2*width-1:0] rd_word;

    assign wr_addr = bitrev(cnt_in);

    always_comb begin
        // start is combinational so the reader begins on the same edge the
        // last sample lands; bin 0 then appears one edge later.
        start     = !areset && en_in && (cnt_in == LAST);
        seq_bad   = en_in && (cnt_in != exp_cnt_q);
        overrun   = start && (state_q == READ) && (rcnt_q != LAST);
        err_d     = err_q | seq_bad | overrun;
        // Resync to the observed count, which equals exp_cnt+1 when in order.
        exp_cnt_d = en_in ? cnt_in + 1'b1 : exp_cnt_q;
        wbank_d   = start ? ~wbank_q : wbank_q;
        rbank_d   = start ? wbank_q : rbank_q;
        rd_word   = rbank_q ? bank1_mem[rcnt_q] : bank0_mem[rcnt_q];
    end

    always_ff @(posedge clk) begin
        if (!areset && en_in) begin
            if (wbank_q) bank1_mem[wr_addr] <= {xin_re, xin_im};
            else         bank0_mem[wr_addr] <= {xin_re, xin_im};
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            exp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            exp_cnt_q <= exp_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= IDLE;
            rcnt_q    <= '0;
            en_out_q  <= 1'b0;
            cnt_out_q <= '0;
            yout_re_q <= '0;
            yout_im_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    en_out_q <= 1'b0;
                    if (start) begin
                        state_q <= READ;
                        rcnt_q  <= '0;
                    end
                end
                READ: begin
                    en_out_q  <= 1'b1;
                    cnt_out_q <= rcnt_q;
                    yout_re_q <= rd_word[2*width-1:width];
                    yout_im_q <= rd_word[width-1:0];
                    // A new frame restarts the read whether or not this one
                    // finished; an unfinished one is flagged as overrun.
                    if (start) begin
                        rcnt_q <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                        if (rcnt_q == LAST) state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    en_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign en_out  = en_out_q;
    assign cnt_out = cnt_out_q;
    assign yout_re = yout_re_q;
    assign yout_im = yout_im_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    // N=3 instance
    logic               en3;
    logic [2:0]         cnt3;
    logic signed [15:0] re3, im3;
    logic               eo3;
    logic [2:0]         co3;
    logic signed [15:0] yre3, yim3;
    logic               err3;

    // N=6 instance
    logic               en6;
    logic [5:0]         cnt6;
    logic signed [15:0] re6, im6;
    logic               eo6;
    logic [5:0]         co6;
    logic signed [15:0] yre6, yim6;
    logic               err6;

    int checks = 0;
    int errors = 0;

    int br3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_reorder #(.width(16), .N(3)) dut3 (
        .clk(clk), .areset(areset), .en_in(en3), .cnt_in(cnt3),
        .xin_re(re3), .xin_im(im3), .en_out(eo3), .cnt_out(co3),
        .yout_re(yre3), .yout_im(yim3), .err(err3)
    );

    fft_reorder #(.width(16), .N(6)) dut6 (
        .clk(clk), .areset(areset), .en_in(en6), .cnt_in(cnt6),
        .xin_re(re6), .xin_im(im6), .en_out(eo6), .cnt_out(co6),
        .yout_re(yre6), .yout_im(yim6), .err(err6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        en3 = 1'b0; cnt3 = '0; re3 = '0; im3 = '0;
        en6 = 1'b0; cnt6 = '0; re6 = '0; im6 = '0;
        step();
        step();
        checks++;
        if ({eo3, co3, yre3, yim3, err3} !== 36'd0) begin
            errors++;
            $display("FAIL reset3 got en=%b cnt=%0d re=%0d im=%0d err=%b exp all 0", eo3, co3, yre3, yim3, err3);
        end
        checks++;
        if ({eo6, co6, yre6, yim6, err6} !== 39'd0) begin
            errors++;
            $display("FAIL reset6 got en=%b cnt=%0d re=%0d im=%0d err=%b exp all 0", eo6, co6, yre6, yim6, err6);
        end
        areset = 1'b0;
        step();
    endtask

    task automatic test_one_frame();
        logic signed [15:0] er, ei;
        for (int c = 0; c < 8; c++) begin
            en3 = 1'b1; cnt3 = 3'(c); re3 = 16'(c); im3 = 16'(-c);
            step();
            checks++;
            if (eo3 !== 1'b0) begin
                errors++;
                $display("FAIL one_frame early en_out c=%0d got %b exp 0", c, eo3);
            end
        end
        en3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            er = 16'(br3[k]);
            ei = 16'(-br3[k]);
            checks++;
            if (eo3 !== 1'b1 || co3 !== 3'(k) || yre3 !== er || yim3 !== ei) begin
                errors++;
                $display("FAIL one_frame k=%0d got en=%b cnt=%0d re=%0d im=%0d exp en=1 cnt=%0d re=%0d im=%0d",
                         k, eo3, co3, yre3, yim3, k, er, ei);
            end
        end
        step();
        checks++;
        if (eo3 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL one_frame tail got en=%b err=%b exp en=0 err=0", eo3, err3);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] er, ei;
        int j, f, k;
        for (int i = 0; i < 32; i++) begin
            if (i < 24) begin
                en3 = 1'b1; cnt3 = 3'(i % 8);
                re3 = 16'(16 * (i / 8) + i % 8); im3 = 16'(-(16 * (i / 8) + i % 8));
            end else begin
                en3 = 1'b0;
            end
            step();
            if (i >= 8) begin
                j = i - 8; f = j / 8; k = j % 8;
                er = 16'(16 * f + br3[k]);
                ei = 16'(-(16 * f + br3[k]));
                checks++;
                if (eo3 !== 1'b1 || co3 !== 3'(k) || yre3 !== er || yim3 !== ei) begin
                    errors++;
                    $display("FAIL b2b f=%0d k=%0d got en=%b cnt=%0d re=%0d im=%0d exp en=1 cnt=%0d re=%0d im=%0d",
                             f, k, eo3, co3, yre3, yim3, k, er, ei);
                end
            end
        end
        step();
        checks++;
        if (eo3 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL b2b tail got en=%b err=%b exp en=0 err=0", eo3, err3);
        end
    endtask

    task automatic test_gap();
        logic signed [15:0] er, ei;
        int c, k;
        for (int i = 0; i < 22; i++) begin
            if (i < 4) begin
                c = i; en3 = 1'b1;
            end else if (i < 9) begin
                c = 7; en3 = 1'b0;  // idle cycles carry a misleading count
            end else if (i < 13) begin
                c = i - 5; en3 = 1'b1;
            end else begin
                c = 0; en3 = 1'b0;
            end
            cnt3 = 3'(c); re3 = 16'(c); im3 = 16'(-c);
            step();
            if (i == 12 || i == 21) begin
                checks++;
                if (eo3 !== 1'b0) begin
                    errors++;
                    $display("FAIL gap idle i=%0d got en=%b exp 0", i, eo3);
                end
            end else if (i >= 13) begin
                k = i - 13;
                er = 16'(br3[k]);
                ei = 16'(-br3[k]);
                checks++;
                if (eo3 !== 1'b1 || co3 !== 3'(k) || yre3 !== er || yim3 !== ei) begin
                    errors++;
                    $display("FAIL gap k=%0d got en=%b cnt=%0d re=%0d im=%0d exp en=1 cnt=%0d re=%0d im=%0d",
                             k, eo3, co3, yre3, yim3, k, er, ei);
                end
            end
        end
        checks++;
        if (err3 !== 1'b0) begin
            errors++;
            $display("FAIL gap err got %b exp 0", err3);
        end
    endtask

    // Bank 1 was last fully written by the third back-to-back frame
    // (re = 32+cnt), so the skipped positions 3 and 4 show that data.
    task automatic test_seq_err();
        int seq [6] = '{0, 1, 2, 5, 6, 7};
        logic signed [15:0] er, ei;
        int src, v, k;
        for (int i = 0; i < 15; i++) begin
            if (i < 6) begin
                en3 = 1'b1; cnt3 = 3'(seq[i]);
                re3 = 16'(64 + seq[i]); im3 = 16'(-(64 + seq[i]));
            end else begin
                en3 = 1'b0;
            end
            step();
            if (i == 2) begin
                checks++;
                if (err3 !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_err before break got %b exp 0", err3);
                end
            end
            if (i >= 3) begin
                checks++;
                if (err3 !== 1'b1) begin
                    errors++;
                    $display("FAIL seq_err sticky i=%0d got %b exp 1", i, err3);
                end
            end
            if (i >= 6 && i < 14) begin
                k = i - 6;
                src = br3[k];
                v = (src == 3 || src == 4) ? 32 + src : 64 + src;
                er = 16'(v);
                ei = 16'(-v);
                checks++;
                if (eo3 !== 1'b1 || co3 !== 3'(k) || yre3 !== er || yim3 !== ei) begin
                    errors++;
                    $display("FAIL seq_err k=%0d got en=%b cnt=%0d re=%0d im=%0d exp en=1 cnt=%0d re=%0d im=%0d",
                             k, eo3, co3, yre3, yim3, k, er, ei);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] er, ei;
        for (int c = 0; c < 4; c++) begin
            en3 = 1'b1; cnt3 = 3'(c); re3 = 16'(200 + c); im3 = 16'(300 + c);
            step();
        end
        areset = 1'b1;
        en3 = 1'b1; cnt3 = 3'd4; re3 = 16'(204); im3 = 16'(304);
        step();
        checks++;
        if ({eo3, co3, yre3, yim3, err3} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid got en=%b cnt=%0d re=%0d im=%0d err=%b exp all 0", eo3, co3, yre3, yim3, err3);
        end
        areset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            en3 = 1'b1; cnt3 = 3'(c); re3 = 16'(8 * c - 30); im3 = 16'(1000 * c);
            step();
            checks++;
            if (eo3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid early en_out c=%0d got %b exp 0", c, eo3);
            end
        end
        en3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            er = 16'(8 * br3[k] - 30);
            ei = 16'(1000 * br3[k]);
            checks++;
            if (eo3 !== 1'b1 || co3 !== 3'(k) || yre3 !== er || yim3 !== ei || err3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got en=%b cnt=%0d re=%0d im=%0d err=%b exp en=1 cnt=%0d re=%0d im=%0d err=0",
                         k, eo3, co3, yre3, yim3, err3, k, er, ei);
            end
        end
    endtask

    task automatic test_n6();
        logic signed [15:0] dre [64];
        logic signed [15:0] dim [64];
        int src;
        for (int i = 0; i < 64; i++) begin
            dre[i] = 16'($urandom);
            dim[i] = 16'($urandom);
        end
        dre[0]  = -16'sd32768; dim[0]  = 16'sd32767;
        dre[63] = 16'sd32767;  dim[63] = -16'sd32768;
        dre[5]  = -16'sd32768; dim[40] = 16'sd32767;
        for (int c = 0; c < 64; c++) begin
            en6 = 1'b1; cnt6 = 6'(c); re6 = dre[c]; im6 = dim[c];
            step();
        end
        en6 = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step();
            src = 0;
            for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) src |= 1 << (5 - b);
            checks++;
            if (eo6 !== 1'b1 || co6 !== 6'(k) || yre6 !== dre[src] || yim6 !== dim[src]) begin
                errors++;
                $display("FAIL n6 k=%0d got en=%b cnt=%0d re=%0d im=%0d exp en=1 cnt=%0d re=%0d im=%0d",
                         k, eo6, co6, yre6, yim6, k, dre[src], dim[src]);
            end
        end
        step();
        checks++;
        if (eo6 !== 1'b0 || err6 !== 1'b0) begin
            errors++;
            $display("FAIL n6 tail got en=%b err=%b exp en=0 err=0", eo6, err6);
        end
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_back_to_back();
        test_gap();
        test_seq_err();
        test_reset_mid();
        test_n6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
